iter_divider: RTL
=================

// Module: iter_divider
// PURPOSE
//  Multi-cycle restoring integer divider; functional unit in the OOO execute stage.
//  Inverse of the adder path: one trial subtract per cycle, one quotient bit per cycle.
//  Accepts one op per valid/ready handshake, tags the result with its ROB tag and
//  holds it until writeback accepts it. Aborts on pipeline flush.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=4)
//  TAG_W  6   ROB tag width
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  reset        in   1      synchronous, active-high
//  in_valid     in   1      request valid
//  in_ready     out  1      unit can accept a request (state==IDLE)
//  dividend     in   WIDTH  numerator
//  divisor      in   WIDTH  denominator
//  is_signed    in   1      1: two's-complement op, 0: unsigned
//  in_tag       in   TAG_W  ROB tag of request
//  flush        in   1      squash in-flight op
//  out_valid    out  1      result valid
//  out_ready    in   1      writeback accepts result
//  quotient     out  WIDTH  result quotient
//  remainder    out  WIDTH  result remainder
//  out_tag      out  TAG_W  tag of result
//  div_by_zero  out  1      divisor was zero
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, quotient/remainder/out_tag/div_by_zero=0.
//  - FSM IDLE->BUSY on in_valid&in_ready&!flush. Latch abs operands, sign flags, tag.
//  - BUSY: step counter 0..WIDTH-1. Each cycle: rem={rem[W-2:0],dvd[W-1]}.
//    Trial = rem - |divisor| (WIDTH+1 bits). If no borrow: rem=trial, q bit=1.
//    Otherwise rem kept, q bit=0. Shift dvd left.
//  - After WIDTH BUSY cycles -> DONE. Latency: accept in cycle t -> out_valid in cycle t+WIDTH+1.
//  - DONE: out_valid=1. Outputs stable until out_valid&out_ready, then -> IDLE.
//    No accept in that same cycle; in_ready rises the next cycle.
//  - Signed: negate quotient if operand signs differ. Remainder takes dividend sign.
//  - Signed overflow: MIN/-1 -> quotient=MIN, remainder=0, div_by_zero=0.
//  - Divide by zero: quotient=all ones, remainder=dividend (unmodified), div_by_zero=1.
//  - flush in any state: -> IDLE next cycle, out_valid=0, result discarded.
//    flush overrides a same-cycle in_valid; that request is not accepted.
//  - reset mid-operation: identical to reset values; no partial result emitted.
//  - Inputs ignored outside the accept cycle. Operand changes while BUSY have no effect.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined:
//    - divisor==0 goes IDLE->DONE directly; out_valid at t+1.
//    - |dividend| < |divisor| goes IDLE->DONE directly; quotient=0, remainder=dividend, out_valid at t+1.
//    - All other ops take the full latency.
//  DIV_EARLY_OUT_EN undefined: every op, including these cases, takes WIDTH+1 cycles.
// TESTING
//  1. Reset then idle -> in_ready=1, out_valid=0, all outputs 0.
//  2. unsigned 100/7, tag=5 -> q=14, r=2, out_tag=5, out_valid exactly cycle t+33 (WIDTH=32).
//  3. signed -7/2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1).
//     signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
//  4. 9/0 -> q=0xFFFFFFFF, r=9, div_by_zero=1.
//     Latency t+1 with DIV_EARLY_OUT_EN, t+33 without.
//  5. Hold out_ready=0 for 10 cycles after out_valid -> outputs and out_valid stable, in_ready=0.
//     Release -> next-cycle in_ready=1.
//  6. flush at BUSY step 10 -> out_valid never asserts for that op, in_ready=1 next cycle.
//     New 20/3 then gives q=6, r=2.

Source files
------------

// File: rtl/iter_divider.sv
// iter_divider: multi-cycle restoring integer divider for the execute stage.
// One trial subtraction and one quotient bit per cycle. Handles signed and
// unsigned operands, divide-by-zero, ROB tag tracking and pipeline flush.
// Optional feature: define DIV_EARLY_OUT_EN to finish divide-by-zero and
// |dividend| < |divisor| requests in a single cycle.
module iter_divider #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] step;
  logic [WIDTH-1:0] rem;       // partial remainder
  logic [WIDTH-1:0] dvd;       // dividend bits shift out the top, quotient bits shift in
  logic [WIDTH-1:0] dsr_abs;   // divisor magnitude
  logic [WIDTH-1:0] dvd_orig;  // raw dividend, returned unchanged on divide-by-zero
  logic             neg_q, neg_r, dz;

  // Request decode: magnitudes and signs of the incoming operands.
  logic             accept, dvd_neg, dsr_neg, early_out;
  logic [WIDTH-1:0] dvd_mag, dsr_mag;

  assign accept  = in_valid && in_ready && !flush;
  assign dvd_neg = is_signed && dividend[WIDTH-1];
  assign dsr_neg = is_signed && divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dsr_mag = dsr_neg ? -divisor  : divisor;

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (divisor == '0) || (dvd_mag < dsr_mag);
`else
  assign early_out = 1'b0;
`endif

  // One restoring step. The shifted remainder is WIDTH+1 bits wide; its top
  // bit is rem[WIDTH-1], and when set the subtraction can never borrow, so
  // the difference is taken modulo 2^WIDTH on the low bits only.
  logic [WIDTH-1:0] rem_shift, diff, rem_step, q_step, q_final, r_final;
  logic             no_borrow, last_step;

  assign rem_shift = {rem[WIDTH-2:0], dvd[WIDTH-1]};
  assign no_borrow = rem[WIDTH-1] || (rem_shift >= dsr_abs);
  assign diff      = rem_shift - dsr_abs;
  assign rem_step  = no_borrow ? diff : rem_shift;
  assign q_step    = {dvd[WIDTH-2:0], no_borrow};
  assign last_step = (step == CNT_W'(WIDTH - 1));

  // MIN / -1 needs no special case: the magnitude 2^(WIDTH-1) is not
  // negated because both signs agree, and it already reads as MIN.
  assign q_final = dz ? '1       : (neg_q ? -q_step   : q_step);
  assign r_final = dz ? dvd_orig : (neg_r ? -rem_step : rem_step);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; flush wins over everything else.
  always_comb begin
    // NOTE: the default assignment first keeps this purely combinational;
    // any path that left state_nxt unassigned would infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)     state_nxt = early_out ? DONE : BUSY;
      BUSY: if (last_step)  state_nxt = DONE;
      DONE: if (out_ready)  state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      step        <= '0;
      rem         <= '0;
      dvd         <= '0;
      dsr_abs     <= '0;
      dvd_orig    <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      out_tag     <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      step     <= '0;
      rem      <= '0;
      dvd      <= dvd_mag;
      dsr_abs  <= dsr_mag;
      dvd_orig <= dividend;
      neg_q    <= dvd_neg ^ dsr_neg;
      neg_r    <= dvd_neg;
      dz       <= (divisor == '0);
      out_tag  <= in_tag;
`ifdef DIV_EARLY_OUT_EN
      if (early_out) begin
        quotient    <= (divisor == '0) ? '1 : '0;
        remainder   <= dividend;
        div_by_zero <= (divisor == '0);
      end
`endif
    end else if (state == BUSY && !flush) begin
      step <= step + CNT_W'(1);
      rem  <= rem_step;
      dvd  <= q_step;
      if (last_step) begin
        quotient    <= q_final;
        remainder   <= r_final;
        div_by_zero <= dz;
      end
    end
  end

endmodule
